// File: rtl/bus_ctrl.sv
// Sequential CPU bus controller: windowed chip-select decode, per-slave wait
// states and ready, registered read data, single-cycle ack and bus-error flag.
module bus_ctrl #(
  parameter int                    NSLAVE   = 9,
  parameter int                    AW       = 32,
  parameter int                    DW       = 16,
  parameter int                    WB       = 4,
  parameter logic [NSLAVE*AW-1:0]  BASE     = '0,
  parameter logic [NSLAVE*AW-1:0]  MASK     = '0,
  parameter logic [NSLAVE*WB-1:0]  WAIT     = '0,
  parameter int                    TIMEOUT  = 255,
  parameter logic [DW-1:0]         ERR_DATA = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_write,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_ack,
  output logic                 cpu_err,
  output logic [AW-1:0]        err_addr,
  output logic [NSLAVE-1:0]    s_cs,
  output logic                 s_we,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  input  logic [NSLAVE*DW-1:0] s_rdata,
  input  logic [NSLAVE-1:0]    s_rdy
);

  // state  | meaning
  // IDLE   | no transfer; samples cpu_req and decodes the address
  // ACCESS | chip select active; waits out wait states and slave ready
  // DONE   | one-cycle ack of a completed transfer
  // ERR    | one-cycle ack+err for unmapped or timed-out access
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  localparam int SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TC_LIM = TW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d, sel_idx;
  logic              hit_any;
  logic              wr_q, wr_d;
  logic [WB-1:0]     wc_q, wc_d;
  logic [TW-1:0]     tc_q, tc_d;
  logic [NSLAVE-1:0] cs_d;
  logic              we_d, ack_d, err_d;
  logic [AW-1:0]     addr_d, err_addr_d;
  logic [DW-1:0]     wdata_d, rdata_d, rdata_sel;
  logic              rdy_sel;

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    hit_any = 1'b0;
    sel_idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if ((cpu_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        hit_any = 1'b1;
        sel_idx = SW'(i);
      end
    end
  end

  assign rdy_sel   = s_rdy[sel_q];
  assign rdata_sel = s_rdata[sel_q*DW +: DW];

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wr_d       = wr_q;
    wc_d       = wc_q;
    tc_d       = tc_q;
    cs_d       = '0;
    we_d       = 1'b0;
    addr_d     = s_addr;
    wdata_d    = s_wdata;
    rdata_d    = cpu_rdata;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    err_addr_d = err_addr;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wr_d    = cpu_write;
          sel_d   = sel_idx;
          wc_d    = WAIT[sel_idx*WB +: WB];
          tc_d    = '0;
          if (hit_any) begin
            state_d       = ACCESS;
            cs_d[sel_idx] = 1'b1;
            we_d          = cpu_write;
          end else begin
            state_d    = ERR;
            ack_d      = 1'b1;
            err_d      = 1'b1;
            err_addr_d = cpu_addr;
            if (!cpu_write) rdata_d = ERR_DATA;
          end
        end
      end
      ACCESS: begin
        if (wc_q == '0 && rdy_sel) begin
          state_d = DONE;
          ack_d   = 1'b1;
          if (!wr_q) rdata_d = rdata_sel;
        end else if (tc_q == TC_LIM) begin
          state_d    = ERR;
          ack_d      = 1'b1;
          err_d      = 1'b1;
          err_addr_d = s_addr;
          if (!wr_q) rdata_d = ERR_DATA;
        end else begin
          cs_d[sel_q] = 1'b1;
          we_d        = wr_q;
          if (wc_q != '0) wc_d = wc_q - WB'(1);
          tc_d = tc_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      wr_q      <= 1'b0;
      wc_q      <= '0;
      tc_q      <= '0;
      s_cs      <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      wc_q      <= wc_d;
      tc_q      <= tc_d;
      s_cs      <= cs_d;
      s_we      <= we_d;
      s_addr    <= addr_d;
      s_wdata   <= wdata_d;
      cpu_rdata <= rdata_d;
      cpu_ack   <= ack_d;
      cpu_err   <= err_d;
      err_addr  <= err_addr_d;
    end
  end

endmodule
